program_loader: RTL and testbench
=================================

# program_loader

Byte-stream program/data loader that sits directly upstream of the CPU load port. It parses framed bytes from a host-side byte source, and emits one CPU load strobe per payload byte. Each strobe carries an address, a data byte and the instruction/data select. While a frame is in progress it holds the CPU in reset, and it reports frame success or failure to the host.

## Interface
- `TIMEOUT_CYCLES`, default 255: idle cycles allowed between bytes inside a frame before abort. Range 1..255.
- `clk` input 1: single clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `in_data` input 8: incoming byte.
- `in_valid` input 1: `in_data` is valid this cycle. A byte is accepted when `in_valid` and `in_ready` are both high.
- `in_ready` output 1: loader can accept a byte.
- `load` output 1: one-cycle CPU load strobe.
- `load_address` output 5: CPU memory address for `load_data`.
- `load_data` output 8: byte to write; drives the CPU data input.
- `is_instruction` output 1: 1 selects instruction memory, 0 selects data memory.
- `cpu_hold` output 1: high while a frame is in progress; ORed into the CPU reset externally.
- `frame_ok` output 1: one-cycle pulse when a frame's checksum matches.
- `frame_err` output 1: one-cycle pulse on any frame error.
- `err_count` output 8: saturating count of frame errors.

## Operation
- Frame format: HDR, LEN, N payload bytes, CHK.
  - HDR: bit7 = 1 (start marker), bit6 = `is_instruction`, bit5 ignored, bits4:0 = start address.
  - LEN: N, legal range 1..32.
  - CHK: XOR of HDR, LEN and all payload bytes.
- FSM states: IDLE, LEN, DATA, CHK.
- IDLE:
  - A byte with bit7 = 0 is accepted and discarded.
  - A byte with bit7 = 1 latches the address and select, seeds the running XOR with that byte, and moves to LEN.
- LEN:
  - LEN = 0 or LEN > 32: `frame_err`, return to IDLE.
  - Otherwise: latch the remaining count, XOR the byte in, go to DATA.
- DATA, for each accepted byte:
  - Register `load_data` = byte, `load_address` = current address, `load` = 1.
  - Increment the address modulo 32 (31 wraps to 0).
  - XOR the byte in and decrement the count.
  - When the count reaches 0, go to CHK.
- CHK:
  - Byte equal to the running XOR: `frame_ok`.
  - Otherwise: `frame_err`.
  - Either way, return to IDLE.
  - Payload writes are never rolled back.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle in LEN, DATA or CHK with no accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: `frame_err`, go to IDLE, clear the counter.
  - The counter is not active in IDLE.
- `err_count` increments on every `frame_err` pulse and saturates at 255.
- `in_ready` is 1 in every state except the reset cycle. Throughput is one byte per cycle.
- `cpu_hold` = 1 exactly when the state is not IDLE, plus the cycle in which the final `load` is presented.

## Timing
- Reset values:
  - state = IDLE.
  - `load`, `frame_ok`, `frame_err`, `cpu_hold` = 0.
  - `load_address` = 0, `load_data` = 0, `is_instruction` = 0, `err_count` = 0.
  - `in_ready` = 0 during the reset cycle and 1 from the cycle after reset deasserts.
- Latency: `load` is high in the cycle after the payload byte is accepted. `load_address`, `load_data` and `is_instruction` are valid in that same cycle.
- Back-to-back payload bytes produce back-to-back `load` pulses with consecutive addresses.
- `frame_ok` and `frame_err` are high in the cycle after the CHK, LEN or timeout event.
- A new HDR may be accepted in the cycle immediately after CHK.
- Reset asserted mid-frame: the next edge forces IDLE and clears all outputs and `err_count`. No `load`, `frame_ok` or `frame_err` is issued for the aborted frame.
- A timeout and an accepted byte on the same cycle: the byte wins and the timeout counter clears.
- `load_address`, `load_data` and `is_instruction` hold their last values when `load` = 0.

## Test plan
- Instruction frame: send C3, 02, A1, B2, D2 on consecutive cycles.
  - Required: `load` at address 3 with data A1, then address 4 with data B2, `is_instruction` = 1.
  - Then a one-cycle `frame_ok`; `err_count` stays 0.
- Address wrap: send 9E, 03, 11, 22, 33, 9D.
  - Required: loads to addresses 30, 31, 0 with data 11, 22, 33 and `is_instruction` = 0.
  - Then `frame_ok`.
- Bad checksum: send C3, 02, A1, B2, 00.
  - Required: both loads still occur.
  - Then `frame_err`, `err_count` = 1, `cpu_hold` returns to 0.
- Illegal length and junk bytes: send 05, 7F (both discarded, no `cpu_hold`), then 80, 00.
  - Required: `frame_err` one cycle after the LEN byte; state returns to IDLE.
  - Repeat 300 times: `err_count` saturates at 255.
- Timeout with `TIMEOUT_CYCLES` = 255: send 80, 02, 55, then hold `in_valid` low.
  - Required: one load of 55 at address 0.
  - `frame_err` 255 idle cycles after the 55 byte is accepted; `cpu_hold` drops.
- Reset mid-frame: assert `reset` for one cycle after HDR+LEN plus 1 payload byte.
  - Required: all outputs 0 the next cycle, no `frame_ok` or `frame_err`.
  - A fresh full frame afterwards loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// Framed byte-stream loader feeding the CPU load port: HDR, LEN, N payload bytes, CHK.
// Latency: load/frame_ok/frame_err appear one cycle after the byte (or timeout) that causes them.
// Backpressure: none; in_ready is high every cycle except the reset cycle, one byte per cycle.
//
// Ports:
//   clk, reset              single rising-edge clock, synchronous active-high reset
//   in_data/in_valid        host byte stream, accepted when in_valid && in_ready
//   in_ready                loader can accept a byte
//   load, load_address,     one-cycle CPU write strobe with its address, byte and
//   load_data, is_instruction   memory select (held when load is low)
//   cpu_hold                high while a frame is in progress (ORed into CPU reset)
//   frame_ok, frame_err     one-cycle frame status pulses
//   err_count               saturating count of frame_err pulses
module program_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load,
    output logic [4:0] load_address,
    output logic [7:0] load_data,
    output logic       is_instruction,
    output logic       cpu_hold,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    localparam logic [7:0] LEN_MAX      = 8'd32;
    // The timeout fires on the idle cycle that would take the counter to TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [4:0] addr;        // next payload address, wraps modulo 32
    logic       sel;         // instruction/data select latched from HDR
    logic [7:0] xor_acc;     // running XOR of HDR, LEN and payload
    logic [5:0] remaining;   // payload bytes still expected (1..32)
    logic [7:0] idle_cnt;    // cycles without an accepted byte inside a frame

    logic accept;
    logic len_bad;
    logic err_now;

    assign accept  = in_valid & in_ready;
    assign len_bad = (in_data == 8'd0) || (in_data > LEN_MAX);

    // Every error source funnels through here so frame_err and err_count stay in step.
    // An accepted byte always beats a timeout on the same cycle.
    always_comb begin
        err_now = 1'b0;
        if (accept) begin
            if (state == S_LEN) begin
                err_now = len_bad;
            end else if (state == S_CHK) begin
                err_now = (in_data != xor_acc);
            end
        end else if (state != S_IDLE) begin
            err_now = (idle_cnt == TIMEOUT_LAST);
        end
    end

    // The final load is presented while the FSM sits in CHK, so the extra
    // load term only makes the hold window explicit.
    assign cpu_hold = (state != S_IDLE) | load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            addr           <= 5'd0;
            sel            <= 1'b0;
            xor_acc        <= 8'd0;
            remaining      <= 6'd0;
            idle_cnt       <= 8'd0;
            in_ready       <= 1'b0;
            load           <= 1'b0;
            load_address   <= 5'd0;
            load_data      <= 8'd0;
            is_instruction <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            err_count      <= 8'd0;
        end else begin
            in_ready  <= 1'b1;
            load      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= err_now;
            if (err_now && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (accept) begin
                idle_cnt <= 8'd0;
                case (state)
                    S_IDLE: begin
                        // Bytes without the start marker are dropped.
                        if (in_data[7]) begin
                            addr    <= in_data[4:0];
                            sel     <= in_data[6];
                            xor_acc <= in_data;
                            state   <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            state <= S_IDLE;
                        end else begin
                            remaining <= in_data[5:0];
                            xor_acc   <= xor_acc ^ in_data;
                            state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        load           <= 1'b1;
                        load_address   <= addr;
                        load_data      <= in_data;
                        is_instruction <= sel;
                        addr           <= addr + 5'd1;
                        xor_acc        <= xor_acc ^ in_data;
                        remaining      <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        // Payload already written stays written whatever the outcome.
                        frame_ok <= (in_data == xor_acc);
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (idle_cnt == TIMEOUT_LAST) begin
                    idle_cnt <= 8'd0;
                    state    <= S_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized frame traffic.
// Outputs are compared every cycle on the falling edge against a byte-position reference model.
// The stream is never stalled by the loader except in the reset cycle.
module tb_program_loader;

    localparam int TIMEOUT = 255;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       load;
    logic [4:0] load_address;
    logic [7:0] load_data;
    logic       is_instruction;
    logic       cpu_hold;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;

    program_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load           (load),
        .load_address   (load_address),
        .load_data      (load_data),
        .is_instruction (is_instruction),
        .cpu_hold       (cpu_hold),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .err_count      (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the frame as "position of the next byte in the frame".
    // pos 1 = length byte, 2..n+1 = payload, n+2 = checksum.
    logic       m_ready = 1'b0;
    logic       m_load = 1'b0, m_ok = 1'b0, m_err = 1'b0;
    logic [4:0] m_addr = 5'd0;
    logic [7:0] m_data = 8'd0;
    logic       m_instr = 1'b0;
    int         m_errcnt = 0;
    bit         m_in_frame = 0;
    int         m_pos = 0, m_n = 0, m_next = 0, m_idle = 0;
    logic       m_sel = 1'b0;
    logic [7:0] m_x = 8'd0;

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        bit acc;
        bit err;
        acc    = v && m_ready;
        err    = 0;
        m_load = 1'b0;
        m_ok   = 1'b0;
        if (r) begin
            m_ready = 1'b0; m_addr = 5'd0; m_data = 8'd0; m_instr = 1'b0;
            m_errcnt = 0; m_in_frame = 0; m_idle = 0; m_err = 1'b0;
            return;
        end
        m_ready = 1'b1;
        if (acc) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (d[7]) begin
                    m_in_frame = 1; m_pos = 1; m_next = int'(d[4:0]); m_sel = d[6]; m_x = d;
                end
            end else if (m_pos == 1) begin
                if (d == 8'd0 || d > 8'd32) begin
                    err = 1; m_in_frame = 0;
                end else begin
                    m_n = int'(d); m_x = m_x ^ d; m_pos = 2;
                end
            end else if (m_pos <= m_n + 1) begin
                m_load = 1'b1; m_addr = 5'(m_next); m_data = d; m_instr = m_sel;
                m_next = (m_next + 1) % 32; m_x = m_x ^ d; m_pos++;
            end else begin
                if (d == m_x) m_ok = 1'b1;
                else err = 1;
                m_in_frame = 0;
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                err = 1; m_in_frame = 0; m_idle = 0;
            end
        end
        m_err = err;
        if (err && m_errcnt < 255) m_errcnt++;
    endtask

    logic [13:0] obs_loads[$];   // {instr, addr, data} seen on the load port
    logic [13:0] exp_loads[$];

    task automatic compare_all();
        check("in_ready",  32'(in_ready),  32'(m_ready));
        check("load",      32'(load),      32'(m_load));
        check("load_addr", 32'(load_address), 32'(m_addr));
        check("load_data", 32'(load_data), 32'(m_data));
        check("is_instr",  32'(is_instruction), 32'(m_instr));
        check("cpu_hold",  32'(cpu_hold),  32'(m_in_frame || m_load));
        check("frame_ok",  32'(frame_ok),  32'(m_ok));
        check("frame_err", 32'(frame_err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_errcnt));
        if (load === 1'b1) obs_loads.push_back({is_instruction, load_address, load_data});
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        reset    = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(r, v, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic expect_loads(input string tag);
        check({tag, "_count"}, 32'(obs_loads.size()), 32'(exp_loads.size()));
        for (int i = 0; i < exp_loads.size(); i++) begin
            if (i < obs_loads.size()) check({tag, "_entry"}, 32'(obs_loads[i]), 32'(exp_loads[i]));
        end
        obs_loads.delete();
        exp_loads.delete();
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 199);
        if (r < 140) return 0;
        if (r < 197) return $urandom_range(1, 3);
        if (r == 197) return TIMEOUT - 1;
        return TIMEOUT;
    endfunction

    task automatic rand_frame();
        int         kind;
        int         n;
        int         rst_at;
        logic [7:0] b[$];
        logic [7:0] x;
        logic [7:0] t;
        kind   = $urandom_range(0, 9);
        rst_at = -1;
        if (kind == 0) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                t = 8'($urandom) & 8'h7F;
                b.push_back(t);
            end
        end else if (kind == 1) begin
            t = 8'($urandom) | 8'h80;
            b.push_back(t);
            t = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(33, 255));
            b.push_back(t);
        end else begin
            t = 8'($urandom) | 8'h80;
            x = t;
            b.push_back(t);
            n = $urandom_range(1, 32);
            t = 8'(n);
            x = x ^ t;
            b.push_back(t);
            for (int i = 0; i < n; i++) begin
                t = 8'($urandom);
                x = x ^ t;
                b.push_back(t);
            end
            if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
            b.push_back(x);
            if (kind == 3) rst_at = $urandom_range(1, b.size() - 1);
        end
        for (int i = 0; i < b.size(); i++) begin
            if (i == rst_at) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            idle(pick_gap());
            send(b[i]);
        end
    endtask

    int timeout_seen;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        step(1'b1, 1'b0, 8'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        step(1'b1, 1'b1, 8'hC3);
        idle(1);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Instruction frame
        obs_loads.delete();
        send(8'hC3); send(8'h02); send(8'hA1); send(8'hB2); send(8'hD2);
        check("instr_ok", 32'(frame_ok), 32'd1);
        check("instr_errcnt", 32'(err_count), 32'd0);
        exp_loads.push_back({1'b1, 5'd3, 8'hA1});
        exp_loads.push_back({1'b1, 5'd4, 8'hB2});
        expect_loads("instr_loads");
        idle(1);
        check("instr_ok_one_cycle", 32'(frame_ok), 32'd0);

        // Address wrap, data memory
        send(8'h9E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h9D);
        check("wrap_ok", 32'(frame_ok), 32'd1);
        exp_loads.push_back({1'b0, 5'd30, 8'h11});
        exp_loads.push_back({1'b0, 5'd31, 8'h22});
        exp_loads.push_back({1'b0, 5'd0,  8'h33});
        expect_loads("wrap_loads");

        // Bad checksum, loads still happen; next HDR directly after CHK
        send(8'hC3); send(8'h02); send(8'hA1); send(8'hB2); send(8'h00);
        check("badchk_err", 32'(frame_err), 32'd1);
        check("badchk_errcnt", 32'(err_count), 32'd1);
        check("badchk_hold", 32'(cpu_hold), 32'd0);
        exp_loads.push_back({1'b1, 5'd3, 8'hA1});
        exp_loads.push_back({1'b1, 5'd4, 8'hB2});
        expect_loads("badchk_loads");

        // Junk bytes and illegal length, repeated to saturation
        send(8'h05);
        check("junk_hold0", 32'(cpu_hold), 32'd0);
        send(8'h7F);
        check("junk_hold1", 32'(cpu_hold), 32'd0);
        for (int i = 0; i < 300; i++) begin
            send(8'h80); send(8'h00);
        end
        check("len0_err", 32'(frame_err), 32'd1);
        check("errcnt_sat", 32'(err_count), 32'd255);
        idle(1);

        // Timeout after a single payload byte
        obs_loads.delete();
        send(8'h80); send(8'h02); send(8'h55);
        timeout_seen = 0;
        for (int i = 1; i <= 300 && timeout_seen == 0; i++) begin
            idle(1);
            if (frame_err === 1'b1) timeout_seen = i;
        end
        check("timeout_latency", 32'(timeout_seen), 32'(TIMEOUT));
        check("timeout_hold", 32'(cpu_hold), 32'd0);
        exp_loads.push_back({1'b0, 5'd0, 8'h55});
        expect_loads("timeout_loads");

        // Reset mid-frame, then a fresh frame
        send(8'h80); send(8'h02); send(8'h55);
        step(1'b1, 1'b0, 8'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_load", 32'(load), 32'd0);
        check("midrst_errcnt", 32'(err_count), 32'd0);
        idle(2);
        obs_loads.delete();
        send(8'hC3); send(8'h02); send(8'hA1); send(8'hB2); send(8'hD2);
        check("midrst_fresh_ok", 32'(frame_ok), 32'd1);
        exp_loads.push_back({1'b1, 5'd3, 8'hA1});
        exp_loads.push_back({1'b1, 5'd4, 8'hB2});
        expect_loads("midrst_fresh_loads");

        // Randomized traffic against the model
        for (int f = 0; f < 120; f++) rand_frame();
        idle(TIMEOUT + 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
